// File: rtl/calculations_if.sv
// Operand/control inputs and result outputs of the execution datapath, as one bundle.
// The master side drives operands and selects; the slave side is the datapath.
interface calculations_if;
  logic [15:0] input_A;
  logic [15:0] input_B;
  logic [15:0] input_PC;
  logic [15:0] input_imm;
  logic [1:0]  input_ALUSrcA;
  logic [1:0]  input_ALUSrcB;
  logic [3:0]  input_ALUOp;
  logic        input_PCSrc;
  logic [15:0] output_ALUOut_sr;
  logic [15:0] output_ALUMuxOut;
  logic [15:0] output_B_sr;
  logic        output_Zero;
  logic        output_negative;
  logic        output_carry;

  modport master (
    output input_A, input_B, input_PC, input_imm,
    output input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_PCSrc,
    input  output_ALUOut_sr, output_ALUMuxOut, output_B_sr,
    input  output_Zero, output_negative, output_carry
  );

  modport slave (
    input  input_A, input_B, input_PC, input_imm,
    input  input_ALUSrcA, input_ALUSrcB, input_ALUOp, input_PCSrc,
    output output_ALUOut_sr, output_ALUMuxOut, output_B_sr,
    output output_Zero, output_negative, output_carry
  );
endinterface

// File: rtl/calculations.sv
// Execution datapath: operand muxes, 16-bit ALU with flags, ALUOut/B registers, next-PC mux.
// Define CALCULATIONS_SHIFT_EN to build the shifter (ops 6/7/8); otherwise those ops yield 0.
module calculations (
  input logic           clk,
  input logic           reset,
  calculations_if.slave bus
);

  typedef enum logic [3:0] {
    OpAdd   = 4'd0,
    OpSub   = 4'd1,
    OpAnd   = 4'd2,
    OpOr    = 4'd3,
    OpXor   = 4'd4,
    OpNor   = 4'd5,
    OpSll   = 4'd6,
    OpSrl   = 4'd7,
    OpSra   = 4'd8,
    OpSlt   = 4'd9,
    OpSltu  = 4'd10,
    OpPassB = 4'd11,
    OpPassA = 4'd12
  } alu_op_e;

  logic [15:0] src_a;
  logic [15:0] src_b;
  logic [16:0] sum;
  logic [15:0] alu_r;
  logic        alu_c;
  logic [15:0] alu_out_q;
  logic [15:0] b_q;

  always_comb begin
    src_a = '0;
    unique case (bus.input_ALUSrcA)
      2'd0: src_a = bus.input_PC;
      2'd1: src_a = bus.input_A;
      2'd2: src_a = 16'h0000;
      2'd3: src_a = bus.input_B;
      default: src_a = '0;
    endcase
  end

  always_comb begin
    src_b = '0;
    unique case (bus.input_ALUSrcB)
      2'd0: src_b = bus.input_B;
      2'd1: src_b = 16'h0002;
      2'd2: src_b = bus.input_imm;
      2'd3: src_b = {bus.input_imm[14:0], 1'b0};
      default: src_b = '0;
    endcase
  end

  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    case (alu_op_e'(bus.input_ALUOp))
      OpAdd: begin
        sum   = {1'b0, src_a} + {1'b0, src_b};
        alu_r = sum[15:0];
        alu_c = sum[16];
      end
      // Carry out of a + ~b + 1 is the "no borrow" indication.
      OpSub: begin
        sum   = {1'b0, src_a} + {1'b0, ~src_b} + 17'd1;
        alu_r = sum[15:0];
        alu_c = sum[16];
      end
      OpAnd:   alu_r = src_a & src_b;
      OpOr:    alu_r = src_a | src_b;
      OpXor:   alu_r = src_a ^ src_b;
      OpNor:   alu_r = ~(src_a | src_b);
`ifdef CALCULATIONS_SHIFT_EN
      OpSll:   alu_r = src_a << src_b[3:0];
      OpSrl:   alu_r = src_a >> src_b[3:0];
      OpSra:   alu_r = $unsigned($signed(src_a) >>> src_b[3:0]);
`else
      OpSll, OpSrl, OpSra: alu_r = '0;
`endif
      OpSlt:   alu_r = {15'd0, $signed(src_a) < $signed(src_b)};
      OpSltu:  alu_r = {15'd0, src_a < src_b};
      OpPassB: alu_r = src_b;
      OpPassA: alu_r = src_a;
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alu_out_q <= '0;
      b_q       <= '0;
    end else begin
      alu_out_q <= alu_r;
      b_q       <= bus.input_B;
    end
  end

  always_comb begin
    bus.output_ALUOut_sr = alu_out_q;
    bus.output_B_sr      = b_q;
    bus.output_ALUMuxOut = bus.input_PCSrc ? alu_out_q : alu_r;
    bus.output_Zero      = (alu_r == 16'h0000);
    bus.output_negative  = alu_r[15];
    bus.output_carry     = alu_c;
  end

endmodule

// File: tb/tb_calculations.sv
// Self-checking bench for calculations: directed scenarios plus a randomised sweep,
// with registered results tracked through a scoreboard queue.
module tb_calculations;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [15:0] exp_alu_q[$];
  logic [15:0] exp_b_q[$];
  logic [15:0] reg_exp;

  calculations_if bus ();

  calculations u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: {carry, R} for one operation.
  function automatic logic [16:0] model(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    logic [15:0] r;
    logic        c;
    int          s;
    r = 16'h0000;
    c = 1'b0;
    case (op)
      4'd0: begin
        s = int'(a) + int'(b);
        r = s[15:0];
        c = (s > 65535);
      end
      4'd1: begin
        r = a - b;
        c = (a >= b);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd5:  r = ~(a | b);
`ifdef CALCULATIONS_SHIFT_EN
      4'd6:  r = a << b[3:0];
      4'd7:  r = a >> b[3:0];
      4'd8: begin
        r = a;
        for (int k = 0; k < int'(b[3:0]); k++) r = {r[15], r[15:1]};
      end
`endif
      4'd9:  r = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      4'd10: r = (a < b) ? 16'h0001 : 16'h0000;
      4'd11: r = b;
      4'd12: r = a;
      default: r = 16'h0000;
    endcase
    return {c, r};
  endfunction

  function automatic logic [15:0] sel_a();
    case (bus.input_ALUSrcA)
      2'd0: return bus.input_PC;
      2'd1: return bus.input_A;
      2'd2: return 16'h0000;
      default: return bus.input_B;
    endcase
  endfunction

  function automatic logic [15:0] sel_b();
    case (bus.input_ALUSrcB)
      2'd0: return bus.input_B;
      2'd1: return 16'h0002;
      2'd2: return bus.input_imm;
      default: return bus.input_imm * 16'd2;
    endcase
  endfunction

  task automatic drive(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b, input logic [15:0] pc,
                       input logic [15:0] imm, input logic pcsrc);
    bus.input_ALUSrcA = sa;
    bus.input_ALUSrcB = sb;
    bus.input_ALUOp   = op;
    bus.input_A       = a;
    bus.input_B       = b;
    bus.input_PC      = pc;
    bus.input_imm     = imm;
    bus.input_PCSrc   = pcsrc;
  endtask

  // Record what the registers should capture at the coming edge, then take the edge.
  task automatic step();
    logic [16:0] m;
    m = model(bus.input_ALUOp, sel_a(), sel_b());
    exp_alu_q.push_back(reset ? 16'h0000 : m[15:0]);
    exp_b_q.push_back(reset ? 16'h0000 : bus.input_B);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e;
    reset = 1'b1;
    drive(2'd1, 2'd0, 4'd0, 16'hAAAA, 16'h5555, 16'h1111, 16'h2222, 1'b0);
    step();
    e = exp_alu_q.pop_front();
    reg_exp = e;
    total++;
    if (bus.output_ALUOut_sr !== e) begin
      bad++;
      $display("FAIL reset_aluout got=%h want=%h", bus.output_ALUOut_sr, e);
    end
    e = exp_b_q.pop_front();
    total++;
    if (bus.output_B_sr !== e) begin
      bad++;
      $display("FAIL reset_bsr got=%h want=%h", bus.output_B_sr, e);
    end
    reset = 1'b0;
    drive(2'd1, 2'd0, 4'd0, 16'h0003, 16'h0004, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if (bus.output_ALUMuxOut !== 16'h0007) begin
      bad++;
      $display("FAIL add_comb got=%h want=0007", bus.output_ALUMuxOut);
    end
    step();
    e = exp_alu_q.pop_front();
    reg_exp = e;
    total++;
    if (bus.output_ALUOut_sr !== e || e !== 16'h0007) begin
      bad++;
      $display("FAIL add_reg got=%h want=0007", bus.output_ALUOut_sr);
    end
    e = exp_b_q.pop_front();
    total++;
    if (bus.output_B_sr !== 16'h0004) begin
      bad++;
      $display("FAIL add_bsr got=%h want=0004", bus.output_B_sr);
    end
  endtask

  task automatic test_pc_branch();
    logic [15:0] e;
    drive(2'd0, 2'd1, 4'd0, 16'h0000, 16'h0000, 16'h0010, 16'h0000, 1'b0);
    #1;
    total++;
    if ({bus.output_ALUMuxOut, bus.output_carry} !== {16'h0012, 1'b0}) begin
      bad++;
      $display("FAIL pc_inc got=%h/%b want=0012/0", bus.output_ALUMuxOut, bus.output_carry);
    end
    drive(2'd0, 2'd3, 4'd0, 16'h0000, 16'h0000, 16'h0020, 16'hFFFE, 1'b0);
    step();
    e = exp_alu_q.pop_front();
    void'(exp_b_q.pop_front());
    reg_exp = e;
    drive(2'd1, 2'd0, 4'd1, 16'h1234, 16'h0042, 16'h0100, 16'h0007, 1'b1);
    #1;
    total++;
    if (bus.output_ALUMuxOut !== 16'h001C) begin
      bad++;
      $display("FAIL branch_target got=%h want=001C", bus.output_ALUMuxOut);
    end
  endtask

  task automatic test_sub_flags();
    drive(2'd1, 2'd0, 4'd1, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if ({bus.output_ALUMuxOut, bus.output_Zero, bus.output_carry, bus.output_negative}
        !== {16'h0000, 3'b110}) begin
      bad++;
      $display("FAIL sub_equal got=%h z=%b c=%b n=%b want=0000 z=1 c=1 n=0",
               bus.output_ALUMuxOut, bus.output_Zero, bus.output_carry, bus.output_negative);
    end
    drive(2'd1, 2'd0, 4'd1, 16'h0003, 16'h0005, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if ({bus.output_ALUMuxOut, bus.output_Zero, bus.output_carry, bus.output_negative}
        !== {16'hFFFE, 3'b001}) begin
      bad++;
      $display("FAIL sub_borrow got=%h z=%b c=%b n=%b want=FFFE z=0 c=0 n=1",
               bus.output_ALUMuxOut, bus.output_Zero, bus.output_carry, bus.output_negative);
    end
    drive(2'd1, 2'd0, 4'd0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if ({bus.output_ALUMuxOut, bus.output_Zero, bus.output_carry} !== {16'h0000, 2'b11}) begin
      bad++;
      $display("FAIL add_wrap got=%h z=%b c=%b want=0000 z=1 c=1",
               bus.output_ALUMuxOut, bus.output_Zero, bus.output_carry);
    end
  endtask

  task automatic test_cmp_shift();
    logic [15:0] want_sra;
    logic [15:0] want_sll;
`ifdef CALCULATIONS_SHIFT_EN
    want_sra = 16'hF800;
    want_sll = 16'h1234 << 3;
`else
    want_sra = 16'h0000;
    want_sll = 16'h0000;
`endif
    drive(2'd1, 2'd0, 4'd9, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if (bus.output_ALUMuxOut !== 16'h0001) begin
      bad++;
      $display("FAIL slt got=%h want=0001", bus.output_ALUMuxOut);
    end
    drive(2'd1, 2'd0, 4'd10, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if (bus.output_ALUMuxOut !== 16'h0000) begin
      bad++;
      $display("FAIL sltu got=%h want=0000", bus.output_ALUMuxOut);
    end
    drive(2'd1, 2'd0, 4'd8, 16'h8000, 16'h0004, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if ({bus.output_ALUMuxOut, bus.output_carry} !== {want_sra, 1'b0}) begin
      bad++;
      $display("FAIL sra got=%h want=%h", bus.output_ALUMuxOut, want_sra);
    end
    drive(2'd1, 2'd0, 4'd6, 16'h1234, 16'h0013, 16'h0000, 16'h0000, 1'b0);
    #1;
    total++;
    if ({bus.output_ALUMuxOut, bus.output_Zero} !== {want_sll, want_sll == 16'h0000}) begin
      bad++;
      $display("FAIL sll got=%h z=%b want=%h", bus.output_ALUMuxOut, bus.output_Zero, want_sll);
    end
  endtask

  task automatic test_reset_priority();
    logic [15:0] e;
    drive(2'd1, 2'd2, 4'd12, 16'h55AA, 16'h0F0F, 16'h0000, 16'h0000, 1'b0);
    step();
    e = exp_alu_q.pop_front();
    void'(exp_b_q.pop_front());
    reg_exp = e;
    total++;
    if (bus.output_ALUOut_sr !== 16'h55AA) begin
      bad++;
      $display("FAIL passa_reg got=%h want=55AA", bus.output_ALUOut_sr);
    end
    drive(2'd1, 2'd2, 4'd12, 16'h1234, 16'h0F0F, 16'h0000, 16'h0000, 1'b0);
    #1;
    reset = 1'b1;
    #1;
    total++;
    if ({bus.output_ALUOut_sr, bus.output_B_sr, bus.output_ALUMuxOut}
        !== {reg_exp, 16'h0F0F, 16'h1234}) begin
      bad++;
      $display("FAIL reset_midcycle got=%h/%h/%h want=%h/0F0F/1234",
               bus.output_ALUOut_sr, bus.output_B_sr, bus.output_ALUMuxOut, reg_exp);
    end
    step();
    e = exp_alu_q.pop_front();
    reg_exp = e;
    total++;
    if (bus.output_ALUOut_sr !== e) begin
      bad++;
      $display("FAIL reset_prio_alu got=%h want=%h", bus.output_ALUOut_sr, e);
    end
    e = exp_b_q.pop_front();
    total++;
    if (bus.output_B_sr !== e) begin
      bad++;
      $display("FAIL reset_prio_b got=%h want=%h", bus.output_B_sr, e);
    end
    reset = 1'b0;
    bus.input_PCSrc = 1'b1;
    #1;
    total++;
    if (bus.output_ALUMuxOut !== 16'h0000) begin
      bad++;
      $display("FAIL post_reset_pc got=%h want=0000", bus.output_ALUMuxOut);
    end
  endtask

  task automatic test_random();
    logic [16:0] m;
    logic [15:0] e;
    logic [15:0] want_mux;
    for (int i = 0; i < 80; i++) begin
      drive(2'($urandom_range(3)), 2'($urandom_range(3)), 4'($urandom_range(15)),
            16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
            1'($urandom_range(1)));
      #1;
      m = model(bus.input_ALUOp, sel_a(), sel_b());
      want_mux = bus.input_PCSrc ? reg_exp : m[15:0];
      total++;
      if ({bus.output_ALUMuxOut, bus.output_Zero, bus.output_negative, bus.output_carry}
          !== {want_mux, m[15:0] == 16'h0000, m[15], m[16]}) begin
        bad++;
        $display("FAIL rand_comb op=%0d got=%h z%b n%b c%b want=%h z%b n%b c%b",
                 bus.input_ALUOp, bus.output_ALUMuxOut, bus.output_Zero,
                 bus.output_negative, bus.output_carry, want_mux,
                 m[15:0] == 16'h0000, m[15], m[16]);
      end
      step();
      e = exp_alu_q.pop_front();
      reg_exp = e;
      total++;
      if (bus.output_ALUOut_sr !== e) begin
        bad++;
        $display("FAIL rand_aluout got=%h want=%h", bus.output_ALUOut_sr, e);
      end
      e = exp_b_q.pop_front();
      total++;
      if (bus.output_B_sr !== e) begin
        bad++;
        $display("FAIL rand_bsr got=%h want=%h", bus.output_B_sr, e);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reg_exp = 16'h0000;
    reset = 1'b1;
    drive(2'd0, 2'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    test_reset();
    test_pc_branch();
    test_sub_flags();
    test_cmp_shift();
    test_reset_priority();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/calculations.md
# calculations

Execution datapath of the 16-bit multi-cycle processor: operand-select muxes, a 4-bit-opcode ALU with zero/negative/carry flags, the ALUOut and B pipeline registers, and the next-PC select mux. It sits between the register-file/immediate block and the fetch/memory block. It supplies PC values, branch targets, memory addresses, store data and writeback results. Control sequencing lives elsewhere; this block only obeys the select and opcode inputs each cycle.

## Interface
- No parameters.
- clk  in  1  system clock; all registers update on rising edge
- reset  in  1  synchronous, active-high; clears internal registers
- input_A  in  16  register-file read port A
- input_B  in  16  register-file read port B
- input_PC  in  16  current program counter
- input_imm  in  16  sign-extended immediate
- input_ALUSrcA  in  2  ALU operand-A select
- input_ALUSrcB  in  2  ALU operand-B select
- input_ALUOp  in  4  ALU operation
- input_PCSrc  in  1  next-PC source select
- output_ALUOut_sr  out  16  registered ALU result
- output_ALUMuxOut  out  16  next-PC value
- output_B_sr  out  16  registered copy of input_B, used as store data
- output_Zero  out  1  ALU result == 0
- output_negative  out  1  ALU result bit 15
- output_carry  out  1  ALU carry/no-borrow

## Operation
- SrcA mux:
  - 0 = input_PC
  - 1 = input_A
  - 2 = 16'h0000
  - 3 = input_B
- SrcB mux:
  - 0 = input_B
  - 1 = 16'h0002 (PC increment)
  - 2 = input_imm
  - 3 = input_imm << 1 (branch offset)
- ALU operations, with R = result, a = SrcA, b = SrcB, all 16-bit modulo 2^16:
  - 0 ADD: a+b; carry = bit 16 of the 17-bit sum.
  - 1 SUB: a+~b+1; carry = bit 16. Carry is 1 when no borrow (a >= b unsigned).
  - 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLL: a << b[3:0].
  - 7 SRL: a >> b[3:0], logical.
  - 8 SRA: a >>> b[3:0], arithmetic.
  - 9 SLT: 16'h0001 if signed a < signed b, else 0.
  - 10 SLTU: unsigned compare, same encoding as SLT.
  - 11 PASSB: b.
  - 12 PASSA: a.
  - 13–15: R = 0.
  - carry = 0 for every op except ADD and SUB.
- Flags: output_Zero = (R == 0); output_negative = R[15]. Flags are combinational from the current R.
- Next-PC mux: output_ALUMuxOut = R when input_PCSrc=0 (sequential PC+2 computed this cycle); output_ALUOut_sr when input_PCSrc=1 (branch/jump target computed in an earlier state).
- Registers load unconditionally every cycle:
  - ALUOut_sr <= R
  - B_sr <= input_B

## Timing
- Combinational path input → muxes → ALU → flags / output_ALUMuxOut settles in the same cycle.
- output_ALUOut_sr and output_B_sr: 1-cycle latency; the value is visible after the next rising edge.
- Reset: on a rising edge with reset=1, ALUOut_sr = 0 and B_sr = 0, regardless of other inputs. Reset has priority over load.
- Reset mid-operation: a result computed in the reset cycle is discarded. Combinational outputs keep following the inputs during reset.
- After reset, with PCSrc=1 and the ALU result unused, output_ALUMuxOut = 0.
- Shift amounts use only b[3:0]; b[15:4] are ignored.
- Shift by 0 returns a.
- Overflow is not flagged; wrap-around is silent (e.g. FFFF+0001 = 0000, Zero=1, carry=1).

## Configuration
- CALCULATIONS_SHIFT_EN: when defined, ALUOp 6/7/8 perform the shifts above.
- When not defined, no shifter is built: ALUOp 6/7/8 return R = 0 (Zero=1, carry=0), and all other ops are unchanged.

## Test plan
- Reset then hold: reset=1 for 1 cycle → ALUOut_sr = 0000, B_sr = 0000. Then SrcA=1, SrcB=0, A=0003, B=0004, Op=ADD → R = 0007 immediately; ALUOut_sr = 0007 and B_sr = 0004 after the next edge.
- PC increment: PC=0010, SrcA=0, SrcB=1, Op=ADD, PCSrc=0 → ALUMuxOut = 0012, carry=0.
- Branch target: PC=0020, imm=FFFE, SrcB=3, Op=ADD; clock; then PCSrc=1 with different inputs → ALUMuxOut = 001C, held from the register.
- SUB flags:
  - A=0005, B=0005 → R=0000, Zero=1, carry=1, neg=0.
  - A=0003, B=0005 → R=FFFE, Zero=0, neg=1, carry=0.
- Compares and shifts:
  - SLT A=FFFF, B=0001 → 0001.
  - SLTU A=FFFF, B=0001 → 0000.
  - SRA A=8000, b=0004 → F800.
  - SLL with b=0013 → A << 3.
- Synchronous reset priority: reset=1 together with A=1234, SrcA=1, SrcB=2 (imm=0), Op=PASSA → after the edge ALUOut_sr = 0000. Asserting reset between edges has no effect until the edge.
